// File: rtl/ft2232h_sync_ctrl.sv
// FPGA-side master for the FT2232H synchronous 245 FIFO: RX into a small FWFT buffer, TX from a one-entry hold register.
// Optional SIWU# flush support is compiled in when FT_SIWU_EN is defined.
module ft2232h_sync_ctrl #(
  parameter int BURST_MAX = 64,
  parameter int RX_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe_o,
  input  logic       rxf_i,
  input  logic       txe_i,
  output logic       oe_o,
  output logic       rd_o,
  output logic       wr_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o
`ifdef FT_SIWU_EN
  ,
  input  logic       flush_i,
  output logic       siwu_o
`endif
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] DEPTH_W    = RX_DEPTH[AW:0];
  localparam logic [AW:0] MIN_FREE   = (AW+1)'(2);
  localparam logic [7:0]  BURST_LAST = 8'(BURST_MAX - 1);

  typedef enum logic [2:0] {IDLE, RX_OE, RX_READ, TX_WRITE, TURN} state_t;

  state_t        state_q, state_d;
  logic          oe_q, oe_d, rd_q, rd_d, wr_q, wr_d;
  logic          data_oe_q, data_oe_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    burst_q, burst_d;
  logic          served_rx_q, served_rx_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem [RX_DEPTH];

  logic capture, consume, tx_load, rx_pop, rx_ok, tx_ok, burst_last;
  logic [AW:0] rx_free, rx_free_after;

  always_comb begin
    capture       = ~rd_q & ~rxf_i;
    consume       = ~wr_q & ~txe_i;
    tx_ready_o    = ~hold_full_q | consume;
    tx_load       = tx_valid_i & tx_ready_o;
    hold_full_d   = (hold_full_q & ~consume) | tx_load;
    hold_d        = tx_load ? tx_data_i : hold_q;
    rx_valid_o    = (count_q != '0);
    rx_data_o     = mem[rptr_q];
    rx_pop        = rx_valid_o & rx_ready_i;
    count_d       = count_q + {{AW{1'b0}}, capture} - {{AW{1'b0}}, rx_pop};
    wptr_d        = capture ? wptr_q + AW'(1) : wptr_q;
    rptr_d        = rx_pop ? rptr_q + AW'(1) : rptr_q;
    rx_free       = DEPTH_W - count_q;
    rx_free_after = DEPTH_W - count_d;
    rx_ok         = ~rxf_i & (rx_free >= MIN_FREE);
    tx_ok         = ~txe_i & hold_full_q;
    burst_last    = (burst_q == BURST_LAST);
  end

  always_comb begin
    state_d     = state_q;
    oe_d        = oe_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    data_oe_d   = data_oe_q;
    data_d      = data_q;
    served_rx_d = served_rx_q;
    burst_d     = burst_q + {7'd0, capture | consume};
    case (state_q)
      IDLE: begin
        // Alternate when both sides are ready; served_rx_q starts low so RX wins first.
        if (rx_ok && (!tx_ok || !served_rx_q)) begin
          state_d     = RX_OE;
          oe_d        = 1'b0;
          rd_d        = 1'b1;
          served_rx_d = 1'b1;
        end else if (tx_ok) begin
          state_d     = TX_WRITE;
          data_oe_d   = 1'b1;
          wr_d        = 1'b0;
          data_d      = hold_q;
          served_rx_d = 1'b0;
        end
      end
      RX_OE: begin
        state_d = RX_READ;
        rd_d    = 1'b0;
      end
      RX_READ: begin
        if (rxf_i || (rx_free_after < MIN_FREE) || (burst_last && tx_ok)) begin
          state_d = TURN;
          rd_d    = 1'b1;
          oe_d    = 1'b1;
        end
      end
      TX_WRITE: begin
        // Keep strobing while a byte is held; an unaccepted byte stays in hold_q for later.
        if (hold_full_d && !txe_i && !(consume && burst_last && rx_ok)) begin
          wr_d   = 1'b0;
          data_d = hold_d;
        end else begin
          state_d   = TURN;
          wr_d      = 1'b1;
          data_oe_d = 1'b0;
        end
      end
      TURN: begin
        state_d   = IDLE;
        oe_d      = 1'b1;
        rd_d      = 1'b1;
        wr_d      = 1'b1;
        data_oe_d = 1'b0;
        burst_d   = 8'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      oe_q        <= 1'b1;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      data_oe_q   <= 1'b0;
      data_q      <= 8'd0;
      burst_q     <= 8'd0;
      served_rx_q <= 1'b0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      oe_q        <= oe_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      data_oe_q   <= data_oe_d;
      data_q      <= data_d;
      burst_q     <= burst_d;
      served_rx_q <= served_rx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) mem[wptr_q] <= data_i;
  end

  assign oe_o      = oe_q;
  assign rd_o      = rd_q;
  assign wr_o      = wr_q;
  assign data_oe_o = data_oe_q;
  assign data_o    = data_q;

`ifdef FT_SIWU_EN
  logic flush_pend_q, flush_pend_d, siwu_q, siwu_d, siwu_fire;

  always_comb begin
    // siwu_q gating keeps the SIWU# pulse to a single cycle even with a back-to-back request.
    siwu_fire    = flush_pend_q & siwu_q & ~hold_full_q & ((state_q == IDLE) | (state_q == TURN));
    flush_pend_d = (flush_pend_q & ~siwu_fire) | flush_i;
    siwu_d       = ~siwu_fire;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flush_pend_q <= 1'b0;
      siwu_q       <= 1'b1;
    end else begin
      flush_pend_q <= flush_pend_d;
      siwu_q       <= siwu_d;
    end
  end

  assign siwu_o = siwu_q;
`endif

endmodule

// File: tb/tb_ft2232h_sync_ctrl.sv
// Directed bench for ft2232h_sync_ctrl: behavioural FT2232H host/chip model plus RX/TX stream endpoints.
// The SIWU test is included when FT_SIWU_EN is defined.
module tb_ft2232h_sync_ctrl;
  localparam int BURST_MAX = 4;
  localparam int RX_DEPTH  = 4;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] data_i, data_o;
  logic       data_oe_o, rxf_i, txe_i, oe_o, rd_o, wr_o;
  logic [7:0] rx_data_o, tx_data_i;
  logic       rx_valid_o, rx_ready_i, tx_valid_i, tx_ready_o;
`ifdef FT_SIWU_EN
  logic       flush_i, siwu_o;
`endif

  always #5 clk = ~clk;

  ft2232h_sync_ctrl #(.BURST_MAX(BURST_MAX), .RX_DEPTH(RX_DEPTH)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .data_i(data_i), .data_o(data_o), .data_oe_o(data_oe_o),
    .rxf_i(rxf_i), .txe_i(txe_i), .oe_o(oe_o), .rd_o(rd_o), .wr_o(wr_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o)
`ifdef FT_SIWU_EN
    , .flush_i(flush_i), .siwu_o(siwu_o)
`endif
  );

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] host_q[$];
  logic [7:0] chip_q[$];
  logic [7:0] rx_got[$];
  logic [7:0] tx_src[$];
  int runs[$];
  int tx_idx, stall_after, stall_left, contention, a3_pres, cyc;
  int oe_fall_cyc, rd_fall_cyc, last_code, run_len, first_dir, last_acc_cyc;
  int siwu_low, siwu_cyc;

  task automatic clear_models();
    host_q.delete(); chip_q.delete(); rx_got.delete(); tx_src.delete(); runs.delete();
    tx_idx = 0; stall_after = -1; stall_left = 0; contention = 0; a3_pres = 0; cyc = 0;
    oe_fall_cyc = -1; rd_fall_cyc = -1; last_code = 0; run_len = 0; first_dir = 0;
    last_acc_cyc = -1; siwu_low = 0; siwu_cyc = -1;
  endtask

  task automatic drive_inputs();
    rxf_i      = (host_q.size() == 0);
    data_i     = (host_q.size() != 0) ? host_q[0] : 8'h00;
    tx_valid_i = (tx_idx < tx_src.size());
    tx_data_i  = tx_valid_i ? tx_src[tx_idx] : 8'h00;
    txe_i      = (stall_left != 0);
  endtask

  task automatic log_dir(input int code);
    if (code != last_code) begin
      if (run_len > 0) runs.push_back(run_len);
      if (first_dir == 0) first_dir = code;
      run_len = 0;
      last_code = code;
    end
    run_len++;
  endtask

  task automatic tick();
    logic cap, acc, rxa, txa;
    logic [7:0] acc_byte, rx_byte;
    @(negedge clk);
    cap = !rd_o && !rxf_i;
    acc = !wr_o && !txe_i;
    acc_byte = data_o;
    rxa = rx_valid_o && rx_ready_i;
    rx_byte = rx_data_o;
    txa = tx_valid_i && tx_ready_o;
    if (data_oe_o && !oe_o) contention++;
    if (!wr_o && data_o == 8'hA3) a3_pres++;
    if (!oe_o && oe_fall_cyc < 0) oe_fall_cyc = cyc;
    if (!rd_o && rd_fall_cyc < 0) rd_fall_cyc = cyc;
`ifdef FT_SIWU_EN
    if (!siwu_o) begin siwu_low++; siwu_cyc = cyc; end
`endif
    @(posedge clk); #1;
    cyc++;
    if (cap) begin
      $display("cyc %0d host->fpga 0x%02h", cyc, host_q[0]);
      void'(host_q.pop_front());
      log_dir(1);
    end
    if (acc) begin
      $display("cyc %0d fpga->host 0x%02h", cyc, acc_byte);
      chip_q.push_back(acc_byte);
      last_acc_cyc = cyc;
      log_dir(2);
    end
    if (rxa) begin
      $display("cyc %0d rx stream 0x%02h", cyc, rx_byte);
      rx_got.push_back(rx_byte);
    end
    if (txa) tx_idx++;
    if (stall_left > 0) stall_left--;
    if (acc && chip_q.size() == stall_after) stall_left = 3;
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    rx_ready_i = 1'b1;
`ifdef FT_SIWU_EN
    flush_i = 1'b0;
`endif
    clear_models();
    drive_inputs();
    run(2);
    reset_i = 1'b0;
  endtask

  initial begin
    // Reset values, observed while reset is held
    reset_i = 1'b1;
    rx_ready_i = 1'b0;
`ifdef FT_SIWU_EN
    flush_i = 1'b0;
`endif
    clear_models();
    drive_inputs();
    run(2);
    check_eq("rst_oe", oe_o, 1);
    check_eq("rst_rd", rd_o, 1);
    check_eq("rst_wr", wr_o, 1);
    check_eq("rst_data_oe", data_oe_o, 0);
    check_eq("rst_data_o", data_o, 0);
    check_eq("rst_rx_valid", rx_valid_o, 0);
    check_eq("rst_tx_ready", tx_ready_o, 1);
`ifdef FT_SIWU_EN
    check_eq("rst_siwu", siwu_o, 1);
`endif

    // Host sends 0x11..0x88 with consumer always ready
    do_reset();
    for (int i = 0; i < 8; i++) host_q.push_back(8'(8'h11 * (i + 1)));
    drive_inputs();
    run(40);
    check_eq("t1_oe_to_rd", rd_fall_cyc - oe_fall_cyc, 1);
    check_eq("t1_count", rx_got.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("t1_byte%0d", i), (i < rx_got.size()) ? rx_got[i] : 8'hxx, 8'(8'h11 * (i + 1)));
    check_eq("t1_valid_idle", rx_valid_o, 0);
    check_eq("t1_oe_idle", oe_o, 1);
    check_eq("t1_contention", contention, 0);

    // Same bytes with consumer stalled, then released
    do_reset();
    rx_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) host_q.push_back(8'(8'h11 * (i + 1)));
    drive_inputs();
    run(20);
    check_eq("t2_rd_high", rd_o, 1);
    check_eq("t2_stalled", host_q.size() != 0, 1);
    check_eq("t2_no_overrun", (8 - host_q.size()) <= RX_DEPTH, 1);
    check_eq("t2_head_valid", rx_valid_o, 1);
    check_eq("t2_head_data", rx_data_o, 8'h11);
    rx_ready_i = 1'b1;
    run(60);
    check_eq("t2_count", rx_got.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("t2_byte%0d", i), (i < rx_got.size()) ? rx_got[i] : 8'hxx, 8'(8'h11 * (i + 1)));

    // TX 0xA0..0xA7 with TXE# high for 3 cycles after the third byte
    do_reset();
    for (int i = 0; i < 8; i++) tx_src.push_back(8'(8'hA0 + i));
    stall_after = 3;
    drive_inputs();
    run(60);
    check_eq("t3_count", chip_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("t3_byte%0d", i), (i < chip_q.size()) ? chip_q[i] : 8'hxx, 8'(8'hA0 + i));
    check_eq("t3_a3_presented", a3_pres, 2);
    check_eq("t3_src_drained", tx_idx, 8);
    check_eq("t3_wr_idle", wr_o, 1);
    check_eq("t3_data_oe_idle", data_oe_o, 0);

    // Both directions pending: alternating 4-byte bursts, RX first
    do_reset();
    for (int i = 0; i < 12; i++) begin
      host_q.push_back(8'(8'hB0 + i));
      tx_src.push_back(8'(8'hC0 + i));
    end
    drive_inputs();
    run(100);
    if (run_len > 0) runs.push_back(run_len);
    check_eq("t4_first_dir_rx", first_dir, 1);
    check_eq("t4_num_bursts", runs.size(), 6);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("t4_burst%0d", i), (i < runs.size()) ? runs[i] : -1, 4);
    check_eq("t4_rx_count", rx_got.size(), 12);
    check_eq("t4_tx_count", chip_q.size(), 12);
    check_eq("t4_rx_last", (rx_got.size() == 12) ? rx_got[11] : 8'hxx, 8'hBB);
    check_eq("t4_tx_last", (chip_q.size() == 12) ? chip_q[11] : 8'hxx, 8'hCB);
    check_eq("t4_contention", contention, 0);

    // Reset in the middle of RX_READ, then a fresh transfer
    do_reset();
    for (int i = 0; i < 8; i++) host_q.push_back(8'(8'h21 + i));
    drive_inputs();
    for (int i = 0; i < 20 && rd_o; i++) tick();
    check_eq("t5_rd_low_seen", !rd_o, 1);
    run(2);
    reset_i = 1'b1;
    tick();
    check_eq("t5_rd_after_rst", rd_o, 1);
    check_eq("t5_oe_after_rst", oe_o, 1);
    check_eq("t5_valid_after_rst", rx_valid_o, 0);
    check_eq("t5_data_oe_after_rst", data_oe_o, 0);
    reset_i = 1'b0;
    host_q.delete();
    rx_got.delete();
    for (int i = 0; i < 4; i++) host_q.push_back(8'(8'h51 + i));
    drive_inputs();
    run(40);
    check_eq("t5_count", rx_got.size(), 4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t5_byte%0d", i), (i < rx_got.size()) ? rx_got[i] : 8'hxx, 8'(8'h51 + i));

`ifdef FT_SIWU_EN
    // Flush with two TX bytes pending: one SIWU# pulse after the last byte
    do_reset();
    tx_src.push_back(8'hD0);
    tx_src.push_back(8'hD1);
    drive_inputs();
    for (int i = 0; i < 20 && wr_o; i++) tick();
    check_eq("t6_wr_low_seen", !wr_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    run(30);
    check_eq("t6_tx_count", chip_q.size(), 2);
    check_eq("t6_siwu_pulses", siwu_low, 1);
    check_eq("t6_siwu_after_last", siwu_cyc > last_acc_cyc, 1);
    check_eq("t6_siwu_idle", siwu_o, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
